life_grid_sequencer: RTL and testbench

Generation scheduler for a small Game-of-Life board held in registers. A single shared cell-rule evaluator is swept over the board one cell per clock, with neighbour counting and the birth/survival rule done internally. Results go to a shadow board, which is committed atomically at the end of each generation. The host loads rows, requests N generations with a start/busy/done handshake, and reads rows back.

---
 rtl/life_grid_sequencer.sv | 130 +++++++++++++
 tb/tb_life_grid_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/life_grid_sequencer.sv
// Game-of-Life generation scheduler: one shared cell evaluator sweeps the board, results are committed atomically per generation.
// Optional LIFE_TORUS_EN macro wraps neighbour indices; otherwise off-board neighbours are dead.
module life_grid_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load_en,
  input  logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] load_addr,
  input  logic [WIDTH-1:0]                       load_row,
  input  logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] rd_addr,
  output logic [WIDTH-1:0]                       rd_row,
  input  logic                                   start,
  input  logic [7:0]                             gens,
  output logic                                   busy,
  output logic                                   done,
  output logic [GEN_W-1:0]                       gen_count
);

  localparam int unsigned AW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, COMMIT, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cur [HEIGHT];
  logic [WIDTH-1:0] nxt [HEIGHT];
  logic [AW-1:0]    row;
  logic [CW-1:0]    col;
  logic [7:0]       remaining;
  logic [3:0]       count;
  logic             cell_next;
  logic             last_cell;

  assign rd_row    = cur[rd_addr];
  assign last_cell = (row == AW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));

  // Neighbour count for the cell under the sweep pointer, always read from cur.
  always_comb begin
    int r;
    int c;
    count = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
`ifdef LIFE_TORUS_EN
          r = (int'(row) + dr + int'(HEIGHT)) % int'(HEIGHT);
          c = (int'(col) + dc + int'(WIDTH)) % int'(WIDTH);
          count = count + 4'(cur[AW'(r)][CW'(c)]);
`else
          r = int'(row) + dr;
          c = int'(col) + dc;
          if (r >= 0 && r < int'(HEIGHT) && c >= 0 && c < int'(WIDTH))
            count = count + 4'(cur[AW'(r)][CW'(c)]);
`endif
        end
      end
    end
    cell_next = (count == 4'd3) | (cur[row][col] & (count == 4'd2));
  end

  // Sequencer FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
      remaining <= 8'd0;
      row       <= '0;
      col       <= '0;
      cur       <= '{default: '0};
      nxt       <= '{default: '0};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) cur[load_addr] <= load_row;
          if (start) begin
            remaining <= gens;
            row       <= '0;
            col       <= '0;
            if (gens == 8'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= SWEEP;
              busy  <= 1'b1;
            end
          end
        end
        SWEEP: begin
          nxt[row][col] <= cell_next;
          if (last_cell) begin
            state <= COMMIT;
          end else if (col == CW'(WIDTH - 1)) begin
            col <= '0;
            row <= row + AW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        COMMIT: begin
          cur       <= nxt;
          gen_count <= gen_count + GEN_W'(1);
          remaining <= remaining - 8'd1;
          row       <= '0;
          col       <= '0;
          if (remaining != 8'd1) begin
            state <= SWEEP;
          end else begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid_sequencer.sv
// Directed bench for life_grid_sequencer: table of board/generation vectors plus handshake corner cases.
module tb_life_grid_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [2:0] load_addr;
  logic [7:0] load_row;
  logic [2:0] rd_addr;
  logic [7:0] rd_row;
  logic       start;
  logic [7:0] gens;
  logic       busy;
  logic       done;
  logic [15:0] gen_count;

  int tests = 0;
  int fails = 0;
  int exp_gc = 0;

  life_grid_sequencer dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_row(load_row), .rd_addr(rd_addr), .rd_row(rd_row),
    .start(start), .gens(gens), .busy(busy), .done(done),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    bit               reload;
    logic [7:0][7:0]  init;
    logic [7:0]       g;
    logic [7:0][7:0]  expb;
  } vec_t;

  vec_t vec[6];

  task automatic check(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, expv, expv);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_row = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic load_board(input logic [7:0][7:0] b);
    for (int r = 0; r < 8; r++) load(3'(r), b[r]);
  endtask

  task automatic check_board(input string name, input logic [7:0][7:0] b);
    for (int r = 0; r < 8; r++) begin
      rd_addr = 3'(r);
      #1;
      check($sformatf("%s row%0d", name, r), int'(rd_row), int'(b[r]));
    end
  endtask

  // Pulse start, then count busy cycles until done; done_cyc is cycles after the start edge.
  task automatic run(input logic [7:0] g, output int busy_cnt, output int done_cyc);
    @(negedge clk);
    start = 1'b1; gens = g;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [7:0][7:0] blinker_h, blinker_v, block, edge_in, edge_out, zero_b;
  int bc, dc, ndone;

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_row = '0;
    rd_addr = '0; start = 1'b0; gens = '0;

    blinker_h = '0; blinker_h[3] = 8'h1C;
    blinker_v = '0; blinker_v[2] = 8'h08; blinker_v[3] = 8'h08; blinker_v[4] = 8'h08;
    block     = '0; block[3] = 8'h18; block[4] = 8'h18;
    edge_in   = '0; edge_in[3] = 8'h83;
    zero_b    = '0;
`ifdef LIFE_TORUS_EN
    edge_out  = '0; edge_out[2] = 8'h01; edge_out[3] = 8'h01; edge_out[4] = 8'h01;
`else
    edge_out  = '0;
`endif

    vec[0] = '{name: "blinker1",   reload: 1'b1, init: blinker_h, g: 8'd1, expb: blinker_v};
    vec[1] = '{name: "blinker_back", reload: 1'b0, init: zero_b,  g: 8'd1, expb: blinker_h};
    vec[2] = '{name: "blinker2",   reload: 1'b1, init: blinker_h, g: 8'd2, expb: blinker_h};
    vec[3] = '{name: "still_life", reload: 1'b1, init: block,     g: 8'd5, expb: block};
    vec[4] = '{name: "edge",       reload: 1'b1, init: edge_in,   g: 8'd1, expb: edge_out};
    vec[5] = '{name: "zero_gens",  reload: 1'b1, init: blinker_h, g: 8'd0, expb: blinker_h};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset gen_count", int'(gen_count), 0);
    check_board("reset", zero_b);

    for (int i = 0; i < 6; i++) begin
      if (vec[i].reload) load_board(vec[i].init);
      run(vec[i].g, bc, dc);
      exp_gc += int'(vec[i].g);
      check($sformatf("%s busy cycles", vec[i].name), bc, int'(vec[i].g) * 65);
      check($sformatf("%s done cycle", vec[i].name), dc, int'(vec[i].g) * 65 + 1);
      check($sformatf("%s busy at done", vec[i].name), int'(busy), 0);
      @(posedge clk); #1;
      check($sformatf("%s done width", vec[i].name), int'(done), 0);
      check($sformatf("%s gen_count", vec[i].name), int'(gen_count), exp_gc % 65536);
      check_board(vec[i].name, vec[i].expb);
    end

    // Load and start in the same IDLE cycle: sweep must see the freshly loaded row.
    load_board(zero_b);
    @(negedge clk);
    load_en = 1'b1; load_addr = 3'd3; load_row = 8'h1C; start = 1'b1; gens = 8'd1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    exp_gc += 1;
    check("load+start done count", ndone, 1);
    check_board("load+start", blinker_v);

    // Load and start during SWEEP must be ignored and not queued.
    load_board(blinker_h);
    @(negedge clk);
    start = 1'b1; gens = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    load_en = 1'b1; load_addr = 3'd0; load_row = 8'hFF; start = 1'b1; gens = 8'd4;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    exp_gc += 1;
    check("ignored done count", ndone, 1);
    check("ignored gen_count", int'(gen_count), exp_gc);
    check_board("ignored", blinker_v);

    // Reset in the middle of a 3-generation run.
    load_board(blinker_h);
    @(negedge clk);
    start = 1'b1; gens = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst gen_count", int'(gen_count), 0);
    check_board("midrst", zero_b);
    repeat (5) begin
      @(posedge clk); #1;
      check("midrst stays idle", int'(busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
